// File: rtl/rs_forney_chien_stream.sv
// ---------------------------------------------------------------------------
// rs_forney_chien_stream
//   Chien search + Forney error evaluator for a Reed-Solomon decoder.
//   On a start pulse the Lambda(x) and Omega(x) coefficient buses are
//   captured. Positions j = N-1 down to 0 are then evaluated at
//   X^-1 = alpha^-j. Each position produces one output beat carrying a
//   location flag and the error magnitude
//   e = X^(1-FCR) * Omega(X^-1) / Lambda'(X^-1).
//   After the last beat is accepted a one-cycle done pulse is issued, and
//   err_cnt / fail describe the whole frame.
//
// Ports
//   clk_in      clock
//   sys_rst_n   synchronous active-low reset
//   start       one-cycle pulse, accepted only while busy = 0
//   lambda_in   Lambda coefficients, coeff k at [k*M +: M]
//   omega_in    Omega coefficients,  coeff k at [k*M +: M]
//   busy        frame in progress (start accept .. done)
//   out_valid   beat valid; out_ready accepts it
//   out_loc     Lambda(X^-1) == 0 at this position
//   out_err     error magnitude, 0 when out_loc = 0
//   out_idx     position index j
//   out_last    beat for j = 0
//   done        one-cycle pulse after the last beat is accepted
//   err_cnt     roots found this frame (saturates at T+1)
//   fail        frame is uncorrectable
// ---------------------------------------------------------------------------
module rs_forney_chien_stream #(
    parameter int         M         = 8,
    parameter int         N         = 255,
    parameter int         T         = 8,
    parameter logic [M:0] PRIM_POLY = 9'h11D,
    parameter int         FCR       = 1
) (
    input  logic                      clk_in,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic [(T+1)*M-1:0]        lambda_in,
    input  logic [T*M-1:0]            omega_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_loc,
    output logic [M-1:0]              out_err,
    output logic [$clog2(N)-1:0]      out_idx,
    output logic                      out_last,
    output logic                      done,
    output logic [$clog2(T+1):0]      err_cnt,
    output logic                      fail
);

    localparam int W_IDX = $clog2(N);
    localparam int W_CNT = $clog2(T + 1) + 1;
    localparam int Q     = (1 << M) - 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // ------------------------------------------------------------------
    // GF(2^M) helpers
    // ------------------------------------------------------------------
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        return a[M-1] ? ((a << 1) ^ PRIM_POLY[M-1:0]) : (a << 1);
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // a^(2^M-2) = a^2 * a^4 * ... * a^(2^(M-1)); maps 0 to 0.
    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        logic [M-1:0] sq;
        logic [M-1:0] r;
        sq = a;
        r  = M'(1);
        for (int i = 1; i < M; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic int exp_mod(input int e);
        int r;
        r = e % Q;
        if (r < 0) r = r + Q;
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] r;
        r = M'(1);
        for (int i = 0; i < e; i++) r = gf_xtime(r);
        return r;
    endfunction

    // step = 0: alpha^(-k*(N-1)) (value at j = N-1); step = 1: alpha^k.
    function automatic logic [(T+1)*M-1:0] coef_tbl(input logic step);
        logic [(T+1)*M-1:0] t;
        t = '0;
        for (int k = 0; k <= T; k++)
            t[k*M +: M] = step ? alpha_pow(k) : alpha_pow(exp_mod(-k * (N - 1)));
        return t;
    endfunction

    localparam logic [(T+1)*M-1:0] C_INIT  = coef_tbl(1'b0);
    localparam logic [(T+1)*M-1:0] C_STEP  = coef_tbl(1'b1);
    // X^-FCR tracker: alpha^(-j*FCR), starting at j = N-1.
    localparam logic [M-1:0]       XF_INIT = alpha_pow(exp_mod(-(N - 1) * FCR));
    localparam logic [M-1:0]       XF_STEP = alpha_pow(exp_mod(FCR));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic              fail_q, fail_d;
    logic [W_CNT-1:0]  deg_q, deg_in;

    logic [M-1:0]      lam_c_q [T+1];
    logic [M-1:0]      om_c_q  [T];
    logic [M-1:0]      xf_q;
    logic [W_IDX-1:0]  j_q;

    // Stage 1: raw evaluations
    logic              s1_valid_q, s1_last_q;
    logic [W_IDX-1:0]  s1_idx_q;
    logic [M-1:0]      s1_lam_q, s1_odd_q, s1_om_q, s1_xf_q;
    // Stage 2: inverse of the odd sum, scaled Omega
    logic              s2_valid_q, s2_last_q, s2_loc_q, s2_dzero_q;
    logic [W_IDX-1:0]  s2_idx_q;
    logic [M-1:0]      s2_inv_q, s2_omx_q;
    // Stage 3: output beat
    logic              s3_valid_q, s3_last_q, s3_loc_q, s3_dzero_q;
    logic [W_IDX-1:0]  s3_idx_q;
    logic [M-1:0]      s3_err_q;

    logic              start_acc, advance, xfer, eval_en;
    logic [M-1:0]      lam_sum, odd_sum, om_sum;

    assign start_acc = start && (state_q == ST_IDLE);
    // The whole pipe and the evaluator freeze only when a beat is waiting.
    assign advance   = !(s3_valid_q && !out_ready);
    assign xfer      = s3_valid_q && out_ready;
    assign eval_en   = (state_q == ST_RUN) && advance;

    // Lambda(X^-1), and the odd-term sum which equals X^-1 * Lambda'(X^-1).
    // Stage 2 therefore scales Omega by X^-FCR instead of X^(1-FCR).
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        lam_sum = '0;
        odd_sum = '0;
        om_sum  = '0;
        for (int k = 0; k <= T; k++) begin
            lam_sum = lam_sum ^ lam_c_q[k];
            if (k % 2 == 1) odd_sum = odd_sum ^ lam_c_q[k];
        end
        for (int k = 0; k < T; k++) om_sum = om_sum ^ om_c_q[k];
    end

    always_comb begin
        deg_in = '0;
        for (int k = 0; k <= T; k++)
            if (lambda_in[k*M +: M] != '0) deg_in = W_CNT'(k);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                  state_d = ST_LOAD;
            ST_LOAD:                              state_d = ST_RUN;
            ST_RUN:   if (advance && j_q == '0)   state_d = ST_FLUSH;
            ST_FLUSH: if (xfer && s3_last_q)      state_d = ST_DONE;
            ST_DONE:                              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        fail_d = fail_q;
        if (start_acc) begin
            cnt_d  = '0;
            fail_d = 1'b0;
        end else if (xfer) begin
            if (s3_loc_q) begin
                if (cnt_q != W_CNT'(T + 1)) cnt_d = cnt_q + W_CNT'(1);
                // A root where Lambda' vanishes is a repeated root.
                if (s3_dzero_q) fail_d = 1'b1;
            end
            if (s3_last_q && (cnt_d != deg_q || deg_q > W_CNT'(T))) fail_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_loc_q   <= 1'b0;
            s3_err_q   <= '0;
            s3_idx_q   <= '0;
            s3_last_q  <= 1'b0;
            s3_dzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            if (advance) begin
                s1_valid_q <= eval_en;
                s2_valid_q <= s1_valid_q;
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    s3_loc_q   <= s2_loc_q;
                    s3_err_q   <= s2_loc_q ? gf_mul(s2_omx_q, s2_inv_q) : '0;
                    s3_idx_q   <= s2_idx_q;
                    s3_last_q  <= s2_last_q;
                    s3_dzero_q <= s2_dzero_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Evaluator and pipeline datapath
    // ------------------------------------------------------------------
    // NOTE: pure datapath registers carry no reset; the valid bits above
    // decide when their contents matter.
    always_ff @(posedge clk_in) begin
        if (start_acc) begin
            for (int k = 0; k <= T; k++)
                lam_c_q[k] <= gf_mul(lambda_in[k*M +: M], C_INIT[k*M +: M]);
            for (int k = 0; k < T; k++)
                om_c_q[k]  <= gf_mul(omega_in[k*M +: M], C_INIT[k*M +: M]);
            xf_q  <= XF_INIT;
            j_q   <= W_IDX'(N - 1);
            deg_q <= deg_in;
        end else if (eval_en) begin
            for (int k = 0; k <= T; k++)
                lam_c_q[k] <= gf_mul(lam_c_q[k], C_STEP[k*M +: M]);
            for (int k = 0; k < T; k++)
                om_c_q[k]  <= gf_mul(om_c_q[k], C_STEP[k*M +: M]);
            xf_q <= gf_mul(xf_q, XF_STEP);
            j_q  <= j_q - W_IDX'(1);
        end

        if (eval_en) begin
            s1_lam_q  <= lam_sum;
            s1_odd_q  <= odd_sum;
            s1_om_q   <= om_sum;
            s1_xf_q   <= xf_q;
            s1_idx_q  <= j_q;
            s1_last_q <= (j_q == '0);
        end

        if (advance && s1_valid_q) begin
            s2_loc_q   <= (s1_lam_q == '0);
            s2_dzero_q <= (s1_odd_q == '0);
            s2_inv_q   <= gf_inv(s1_odd_q);
            s2_omx_q   <= gf_mul(s1_om_q, s1_xf_q);
            s2_idx_q   <= s1_idx_q;
            s2_last_q  <= s1_last_q;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = s3_valid_q;
    assign out_loc   = s3_loc_q;
    assign out_err   = s3_err_q;
    assign out_idx   = s3_idx_q;
    assign out_last  = s3_last_q;
    assign err_cnt   = cnt_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_rs_forney_chien_stream.sv
// ---------------------------------------------------------------------------
// tb_rs_forney_chien_stream
//   Directed frames for rs_forney_chien_stream. Expected beats are queued
//   when a frame is set up; a separate monitor pops and compares each beat
//   the DUT transfers, and checks that stalled outputs hold.
// ---------------------------------------------------------------------------
module tb_rs_forney_chien_stream;

    localparam int M   = 8;
    localparam int N   = 255;
    localparam int T   = 8;
    localparam int FCR = 1;

    logic                 clk_in = 1'b0;
    logic                 sys_rst_n;
    logic                 start;
    logic [(T+1)*M-1:0]   lambda_in;
    logic [T*M-1:0]       omega_in;
    logic                 busy, out_valid, out_loc, out_last, done, fail;
    logic                 out_ready = 1'b1;
    logic [M-1:0]         out_err;
    logic [7:0]           out_idx;
    logic [4:0]           err_cnt;

    rs_forney_chien_stream #(
        .M(M), .N(N), .T(T), .PRIM_POLY(9'h11D), .FCR(FCR)
    ) dut (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .lambda_in (lambda_in),
        .omega_in  (omega_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_loc   (out_loc),
        .out_err   (out_err),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .err_cnt   (err_cnt),
        .fail      (fail)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       loc;
        logic [7:0] err;
        logic [7:0] idx;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         ready_mode = 0;

    logic [7:0] gexp [0:509];
    int         glog [0:255];
    logic [7:0] lam  [0:T];
    logic [7:0] om   [0:T-1];
    logic       loc_map [0:255];
    logic [7:0] err_map [0:255];
    int         pos_q[$];
    logic [7:0] val_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return gexp[glog[a] + glog[b]];
    endfunction

    task automatic init_tables();
        logic [8:0] v;
        gexp[0] = 8'd1;
        for (int i = 1; i < 510; i++) begin
            v = {gexp[i-1], 1'b0};
            if (v[8]) v = v ^ 9'h11D;
            gexp[i] = v[7:0];
        end
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
    endtask

    task automatic clear_frame();
        for (int j = 0; j < 256; j++) begin
            loc_map[j] = 1'b0;
            err_map[j] = 8'd0;
        end
        for (int k = 0; k <= T; k++) lam[k] = 8'd0;
        for (int k = 0; k < T; k++)  om[k]  = 8'd0;
        lam[0] = 8'd1;
    endtask

    // Lambda = prod(1 + X_l x); Omega = S(x)*Lambda(x) mod x^2T with
    // S_i = sum e_l * X_l^(FCR+i). Expected beats come from the error list.
    task automatic build_from_errors();
        logic [7:0] s [0:2*T-1];
        clear_frame();
        foreach (pos_q[l]) begin
            for (int k = T; k >= 1; k--) lam[k] = lam[k] ^ mul(gexp[pos_q[l]], lam[k-1]);
            loc_map[pos_q[l]] = 1'b1;
            err_map[pos_q[l]] = val_q[l];
        end
        for (int i = 0; i < 2*T; i++) begin
            s[i] = 8'd0;
            foreach (pos_q[l]) s[i] = s[i] ^ mul(val_q[l], gexp[(pos_q[l] * (FCR + i)) % 255]);
        end
        for (int k = 0; k < T; k++)
            for (int i = 0; i <= k; i++) om[k] = om[k] ^ mul(s[i], lam[k-i]);
    endtask

    task automatic load_and_push();
        beat_t b;
        for (int k = 0; k <= T; k++) lambda_in[k*M +: M] = lam[k];
        for (int k = 0; k < T; k++)  omega_in[k*M +: M]  = om[k];
        for (int j = N - 1; j >= 0; j--) begin
            b.loc  = loc_map[j];
            b.err  = err_map[j];
            b.idx  = 8'(j);
            b.last = (j == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_frame(input string tag, input int exp_cnt, input logic exp_fail,
                             input logic timing, input logic mid_start);
        int n;
        int first_v;
        logic [(T+1)*M-1:0] saved;
        saved = lambda_in;
        @(posedge clk_in); #1; start = 1'b1;
        @(posedge clk_in); #1; start = 1'b0;
        n = 0;
        first_v = -1;
        while (!done && n < 5000) begin
            @(posedge clk_in); #1;
            n++;
            if (out_valid && first_v < 0) first_v = n;
            if (mid_start && n == 100) begin start = 1'b1; lambda_in = '1; end
            if (mid_start && n == 101) begin start = 1'b0; lambda_in = saved; end
        end
        check({tag, " done_seen"}, 32'(done), 32'd1);
        if (timing) begin
            check({tag, " done_cycle"}, n, N + 4);
            check({tag, " first_valid_cycle"}, first_v, 4);
        end
        check({tag, " err_cnt"}, 32'(err_cnt), exp_cnt);
        check({tag, " fail"}, 32'(fail), 32'(exp_fail));
        check({tag, " beats_left"}, exp_q.size(), 0);
        @(posedge clk_in); #1;
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge clk_in); #1;
            out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic  stall_prev;
        logic [17:0] held;
        beat_t e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_in);
            if (stall_prev)
                check("stall_hold", {13'd0, out_valid, out_loc, out_err, out_idx, out_last},
                      {13'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat idx=%0d", e.idx),
                          {14'd0, out_loc, out_err, out_idx, out_last}, {14'd0, e});
                end
            end
            stall_prev = out_valid && !out_ready && sys_rst_n;
            held = {out_loc, out_err, out_idx, out_last};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_tables();
        sys_rst_n = 1'b0;
        start     = 1'b0;
        lambda_in = '0;
        omega_in  = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset busy", 32'(busy), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset done", 32'(done), 0);
        check("reset err_cnt", 32'(err_cnt), 0);
        check("reset fail", 32'(fail), 0);
        sys_rst_n = 1'b1;

        // 1. Reset in the middle of RUN
        pos_q = '{5};
        val_q = '{8'h3C};
        build_from_errors();
        load_and_push();
        @(posedge clk_in); #1; start = 1'b1;
        @(posedge clk_in); #1; start = 1'b0;
        repeat (40) @(posedge clk_in);
        #1;
        check("midrun busy", 32'(busy), 1);
        check("midrun out_valid", 32'(out_valid), 1);
        sys_rst_n = 1'b0;
        @(posedge clk_in); #1;
        check("abort busy", 32'(busy), 0);
        check("abort out_valid", 32'(out_valid), 0);
        check("abort done", 32'(done), 0);
        exp_q.delete();
        sys_rst_n = 1'b1;

        // 2. No errors
        clear_frame();
        load_and_push();
        run_frame("no_err", 0, 1'b0, 1'b1, 1'b0);

        // 3. Single error at j=5, value 0x3C
        pos_q = '{5};
        val_q = '{8'h3C};
        build_from_errors();
        load_and_push();
        run_frame("single", 1, 1'b0, 1'b1, 1'b0);

        // 4. Eight errors, random nonzero magnitudes
        pos_q = '{0, 1, 50, 100, 128, 200, 253, 254};
        val_q.delete();
        for (int i = 0; i < 8; i++) val_q.push_back(8'($urandom_range(1, 255)));
        build_from_errors();
        load_and_push();
        run_frame("eight", 8, 1'b0, 1'b1, 1'b0);

        // 5. Single error with random backpressure
        pos_q = '{5};
        val_q = '{8'h3C};
        build_from_errors();
        load_and_push();
        ready_mode = 1;
        run_frame("stall", 1, 1'b0, 1'b0, 1'b0);
        ready_mode = 0;

        // 6. Lambda = 1 + alpha^14 x^2: one double root at j=7, Lambda'=0.
        //    A start pulse mid-frame must be ignored.
        clear_frame();
        lam[2] = gexp[14];
        om[0]  = 8'h55;
        om[1]  = 8'h12;
        loc_map[7] = 1'b1;
        err_map[7] = 8'h00;
        load_and_push();
        run_frame("double_root", 1, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
